// File: rtl/buffer_msj_pkg.sv
// Shared constants and helpers for the buffer_msj message buffer.
package buffer_msj_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/buffer_msj_ram.sv
// Message storage: one write port, one asynchronous read port, no reset.
module ram_msj #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/buffer_msj.sv
// Circular message buffer with first-word-fall-through output and
// sticky overflow/underflow flags.
module buffer_msj
    import buffer_msj_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            data_input,
    input  logic                        wr_en,
    input  logic                        rd_en,
    input  logic                        flush,
    input  logic                        err_clr,
    output logic [WIDTH-1:0]            data_output,
    output logic                        valid,
    output logic                        full,
    output logic [ptr_w(DEPTH):0]       count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] w_rdata;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // A full buffer still accepts a write when the head is popped in the same cycle.
    assign w_wr_acc  = wr_en & (~w_full | rd_en) & ~flush;
    assign w_rd_acc  = rd_en & ~w_empty & ~flush;
    assign w_ovf_set = wr_en & w_full & ~rd_en & ~flush;
    assign w_unf_set = rd_en & w_empty & ~flush;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_wr_acc) r_wptr <= r_wptr + PW'(1);
                if (w_rd_acc) r_rptr <= r_rptr + PW'(1);
                r_count <= w_count_nxt;
            end
            r_overflow  <= (r_overflow & ~err_clr) | w_ovf_set;
            r_underflow <= (r_underflow & ~err_clr) | w_unf_set;
        end
    end

    ram_msj #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc & ~reset),
        .i_waddr (r_wptr),
        .i_wdata (data_input),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    assign valid       = ~w_empty;
    assign full        = w_full;
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign data_output = w_empty ? '0 : w_rdata;

endmodule

// File: tb/tb_buffer_msj.sv
// Directed and randomized checks of buffer_msj against a queue model.
module tb_buffer_msj;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] data_input;
    logic         wr_en;
    logic         rd_en;
    logic         flush;
    logic         err_clr;
    logic [W-1:0] data_output;
    logic         valid;
    logic         full;
    logic [2:0]   count;
    logic         overflow;
    logic         underflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] q[$];
    bit           m_ovf;
    bit           m_unf;

    buffer_msj #(.WIDTH(W), .DEPTH(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_input  (data_input),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .flush       (flush),
        .err_clr     (err_clr),
        .data_output (data_output),
        .valid       (valid),
        .full        (full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] exp_d;
        exp_d = (q.size() != 0) ? q[0] : '0;
        check({tag, ".count"}, 64'(count), 64'(q.size()));
        check({tag, ".valid"}, 64'(valid), 64'(q.size() != 0));
        check({tag, ".full"}, 64'(full), 64'(q.size() == D));
        check({tag, ".dout"}, 64'(data_output), 64'(exp_d));
        check({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
        check({tag, ".unf"}, 64'(underflow), 64'(m_unf));
    endtask

    task automatic model(input bit r, input bit w, input bit rd,
                         input bit f, input bit ec, input logic [W-1:0] d);
        bit is_full;
        bit is_empty;
        if (r) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
            return;
        end
        if (ec) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (f) begin
            q.delete();
            return;
        end
        is_full  = (q.size() == D);
        is_empty = (q.size() == 0);
        if (w && is_full && !rd) m_ovf = 1;
        if (rd && is_empty) m_unf = 1;
        if (rd && !is_empty) void'(q.pop_front());
        if (w && (!is_full || rd)) q.push_back(d);
    endtask

    task automatic step(input string tag, input bit r, input bit w,
                        input bit rd, input bit f, input bit ec,
                        input logic [W-1:0] d);
        reset      = r;
        wr_en      = w;
        rd_en      = rd;
        flush      = f;
        err_clr    = ec;
        data_input = d;
        @(posedge clk);
        model(r, w, rd, f, ec, d);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1; wr_en = 0; rd_en = 0; flush = 0; err_clr = 0;
        data_input = '0;
        m_ovf = 0; m_unf = 0;

        step("rst", 1, 0, 0, 0, 0, 8'h00);
        check("rst.dout0", 64'(data_output), 64'h0);

        step("w_a5", 0, 1, 0, 0, 0, 8'hA5);
        check("lat.dout", 64'(data_output), 64'hA5);
        step("r_a5", 0, 0, 1, 0, 0, 8'h00);
        check("rd.valid0", 64'(valid), 64'h0);

        for (int i = 1; i <= 4; i++) step("fill", 0, 1, 0, 0, 0, W'(i));
        check("fill.count4", 64'(count), 64'h4);
        step("ovf", 0, 1, 0, 0, 0, 8'h05);
        check("ovf.set", 64'(overflow), 64'h1);
        for (int i = 1; i <= 4; i++) begin
            check("drain.head", 64'(data_output), 64'(i));
            step("drain", 0, 0, 1, 0, 0, 8'h00);
        end
        step("clr", 0, 0, 0, 0, 1, 8'h00);

        for (int i = 1; i <= 4; i++) step("fill2", 0, 1, 0, 0, 0, W'(i));
        step("wr_rd_full", 0, 1, 1, 0, 0, 8'h10);
        check("wrrd.count", 64'(count), 64'h4);
        check("wrrd.ovf", 64'(overflow), 64'h0);
        for (int i = 0; i < 4; i++) step("drain2", 0, 0, 1, 0, 0, 8'h00);

        step("unf", 0, 0, 1, 0, 0, 8'h00);
        check("unf.set", 64'(underflow), 64'h1);
        step("unf_clr", 0, 0, 0, 0, 1, 8'h00);
        step("unf_wr", 0, 1, 1, 0, 0, 8'h33);
        check("unfwr.dout", 64'(data_output), 64'h33);
        step("pop33", 0, 0, 1, 0, 1, 8'h00);

        for (int i = 0; i < 12; i++) begin
            step("wrap_w", 0, 1, 0, 0, 0, W'(8'h40 + i));
            step("wrap_r", 0, 0, 1, 0, 0, 8'h00);
        end
        step("pre_fl1", 0, 1, 0, 0, 0, 8'h61);
        step("pre_fl2", 0, 1, 0, 0, 0, 8'h62);
        step("flush_wr", 0, 1, 0, 1, 0, 8'h63);
        check("flush.count", 64'(count), 64'h0);
        step("post_fl", 0, 0, 0, 0, 0, 8'h00);

        for (int i = 0; i < 4; i++) step("f3", 0, 1, 0, 0, 0, W'(8'h70 + i));
        step("f3_ovf", 0, 1, 0, 0, 0, 8'h7F);
        step("f3_rd", 0, 0, 1, 0, 0, 8'h00);
        step("rst_mid", 1, 1, 1, 1, 1, 8'hEE);
        check("rstmid.ovf", 64'(overflow), 64'h0);

        for (int i = 0; i < 400; i++) begin
            bit r, w, rd, f, ec;
            r  = ($urandom_range(0, 59) == 0);
            w  = ($urandom_range(0, 99) < 55);
            rd = ($urandom_range(0, 99) < 50);
            f  = ($urandom_range(0, 29) == 0);
            ec = !f && ($urandom_range(0, 11) == 0);
            step("rand", r, w, rd, f, ec, W'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
